clk_div_ratio_ctrl: RTL and testbench
=====================================

# clk_div_ratio_ctrl

Run-time sequencer for the integer clock divider. It accepts ratio-change requests over a valid/ready handshake and validates them. It swaps the divider ratio glitch-free: wait for a low phase of the divided clock, freeze the divider, reset it, load the new ratio, let it settle, then re-enable. It sits between the configuration/register interface and the divider's I_clk_en, I_rst_n and I_div_ratio inputs, all in the I_ref_clk domain.

## Interface
- RATIO_W, 8, width of ratio fields
- DEFAULT_RATIO, 2, ratio loaded at reset
- MAX_RATIO, 29, largest legal ratio; the divider's 4-bit counter reaches half+1 ≤ 15 for odd ratios
- SETTLE_CYCLES, 4, cycles the divider stays disabled after reload (≥1)
- TIMEOUT_CYCLES, 64, maximum wait for a low divided-clock phase
- I_ref_clk  in  1  reference clock; the only clock
- I_rst  in  1  synchronous reset, active-high
- I_req_valid  in  1  ratio-change request
- I_req_ratio  in  RATIO_W  requested ratio
- o_req_ready  out  1  request can be accepted
- I_div_clk  in  1  divider output, registered on I_ref_clk
- o_div_en  out  1  to divider I_clk_en
- o_div_rst_n  out  1  to divider I_rst_n; one-cycle low pulse on reload
- o_div_ratio  out  RATIO_W  to divider I_div_ratio
- o_busy  out  1  reload sequence in progress
- o_done  out  1  one-cycle pulse when a request completes
- o_err  out  1  sticky: last request rejected or timed out

## Operation
- All outputs are registered.
- States: INIT, RUN, WAIT_LOW, GATE, APPLY, SETTLE.
- Reset state is INIT. While I_rst is high, outputs hold these values: o_div_en=0, o_div_rst_n=0, o_div_ratio=DEFAULT_RATIO, o_req_ready=0, o_busy=1, o_done=0, o_err=0.
- INIT → SETTLE after one cycle. o_div_rst_n is low during INIT.
- RUN: o_div_en=1, o_req_ready=1, o_busy=0. A request is accepted on an edge where I_req_valid and o_req_ready are both high. Every accepted request is consumed.
  - Ratio < 2 or > MAX_RATIO: stay in RUN, o_err=1 from the next cycle, no o_done.
  - Ratio equal to current o_div_ratio: stay in RUN, o_done pulses next cycle, o_err cleared.
  - Otherwise: latch the pending ratio, clear o_err, go to WAIT_LOW.
- WAIT_LOW: o_div_en=1, o_req_ready=0. Go to GATE on the first edge where I_div_clk=0. After TIMEOUT_CYCLES cycles without a low phase, go to GATE anyway and set o_err.
- GATE: o_div_en=0 for one cycle.
- APPLY: one cycle. o_div_rst_n=0; o_div_ratio takes the pending ratio.
- SETTLE: o_div_en=0, o_div_rst_n=1, for SETTLE_CYCLES cycles, then RUN.
- o_done pulses in the first RUN cycle after a SETTLE that followed an accepted request. There is no o_done after the INIT sequence.
- o_div_ratio changes only in APPLY (or at reset). It never changes while o_div_en=1.
- Reset mid-sequence abandons the pending ratio; the block returns to the INIT values.

## Timing
- Request accepted at edge N with I_div_clk low at edge N+1: GATE in cycle N+1, APPLY in N+2, SETTLE N+3 … N+2+SETTLE_CYCLES, RUN with o_done=1 from edge N+3+SETTLE_CYCLES.
  - Minimum latency is 3+SETTLE_CYCLES cycles.
  - Each cycle I_div_clk stays high adds one cycle, up to TIMEOUT_CYCLES.
- Rejected or same-ratio request: o_err or o_done appears one cycle after acceptance; o_req_ready stays high.
- o_req_ready is low from the cycle after acceptance until RUN. I_req_valid held high across that time is not re-accepted until RUN.
- After release of I_rst: INIT for 1 cycle, SETTLE for SETTLE_CYCLES cycles, then o_div_en=1 and o_req_ready=1.

## Structure
- Package clk_div_pkg holds:
  - the state enum;
  - DIV_CNT_W=4 and the derived MAX_RATIO limit;
  - the ratio-range check function.
- Sub-module clk_div_timer: loadable down-counter with a zero flag. It is shared by SETTLE and the WAIT_LOW timeout and is sized to clog2(max(SETTLE_CYCLES, TIMEOUT_CYCLES)+1).
- Verification instantiates the controller together with the divider.

## Test plan
- Reset, release, no requests → o_div_en rises SETTLE_CYCLES+1 cycles after release; o_div_ratio=2; divider output toggles every cycle (period 2).
- Request ratio 5 while I_div_clk is low → o_done after 3+SETTLE_CYCLES cycles; one o_div_rst_n low pulse; divided-clock period is 5 afterwards; no high pulse shorter than 2 reference cycles.
- Request ratio 1, then ratio 30 → each consumed; o_err=1 one cycle later; o_div_ratio stays unchanged; no o_done.
- Request equal to the current ratio → o_done next cycle; o_div_en never drops.
- I_div_clk forced high for 100 cycles during a request → GATE after TIMEOUT_CYCLES; o_err=1; new ratio still applied; o_done pulses.
- I_rst asserted during SETTLE → all outputs take reset values next edge; pending ratio discarded; o_div_ratio=DEFAULT_RATIO.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared types and limits for the clock-divider ratio sequencer.
package clk_div_pkg;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_RUN,
    ST_WAIT_LOW,
    ST_GATE,
    ST_APPLY,
    ST_SETTLE
  } state_e;

  localparam int DIV_CNT_W = 4;
  // Odd ratio r drives the divider counter to r/2+1, which must fit in DIV_CNT_W bits.
  localparam int DIV_MAX_RATIO = 2 * ((2 ** DIV_CNT_W) - 2) + 1;

  function automatic logic ratio_in_range(input int ratio, input int max_ratio);
    return (ratio >= 2) && (ratio <= max_ratio);
  endfunction

endpackage

// File: rtl/clk_div_timer.sv
// Loadable saturating down-counter with a zero flag; load wins over decrement.
// Zero flag reflects the registered count, so it trails a load by one cycle.
module clk_div_timer #(
  parameter int W = 7
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/clk_div_ratio_ctrl.sv
// Glitch-free ratio swap for the integer divider: wait low, gate, reset+load, settle, re-enable.
// Accept-to-done is 3+SETTLE_CYCLES cycles plus one per high divided-clock sample; ready is low while busy.
module clk_div_ratio_ctrl
  import clk_div_pkg::*;
#(
  parameter int RATIO_W        = 8,
  parameter int DEFAULT_RATIO  = 2,
  parameter int MAX_RATIO      = DIV_MAX_RATIO,
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic               I_ref_clk,
  input  logic               I_rst,
  input  logic               I_req_valid,
  input  logic [RATIO_W-1:0] I_req_ratio,
  output logic               o_req_ready,
  input  logic               I_div_clk,
  output logic               o_div_en,
  output logic               o_div_rst_n,
  output logic [RATIO_W-1:0] o_div_ratio,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_err
);

  localparam int TMR_MAX = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] SETTLE_LOAD  = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [TMR_W-1:0] TIMEOUT_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [RATIO_W-1:0] DEF_RATIO  = RATIO_W'(DEFAULT_RATIO);

  state_e             state_q, state_d;
  logic [RATIO_W-1:0] pend_q, pend_d;
  logic               from_req_q, from_req_d;
  logic               err_q, err_d;
  logic               done_q, done_d;
  logic               en_q, en_d;
  logic               rst_n_q, rst_n_d;
  logic               rdy_q, rdy_d;
  logic               busy_q, busy_d;
  logic [RATIO_W-1:0] ratio_q, ratio_d;

  logic               tmr_load;
  logic [TMR_W-1:0]   tmr_val;
  logic               tmr_zero;

  logic accept;
  logic req_legal;
  logic req_same;

  assign accept    = I_req_valid && rdy_q;
  assign req_legal = ratio_in_range(int'(I_req_ratio), MAX_RATIO);
  assign req_same  = (I_req_ratio == ratio_q);

  clk_div_timer #(.W(TMR_W)) u_timer (
    .clk_i      (I_ref_clk),
    .rst_i      (I_rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .zero_o     (tmr_zero)
  );

  always_ff @(posedge I_ref_clk) begin
    if (I_rst) begin
      state_q    <= ST_INIT;
      pend_q     <= DEF_RATIO;
      from_req_q <= 1'b0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
      en_q       <= 1'b0;
      rst_n_q    <= 1'b0;
      rdy_q      <= 1'b0;
      busy_q     <= 1'b1;
      ratio_q    <= DEF_RATIO;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      from_req_q <= from_req_d;
      err_q      <= err_d;
      done_q     <= done_d;
      en_q       <= en_d;
      rst_n_q    <= rst_n_d;
      rdy_q      <= rdy_d;
      busy_q     <= busy_d;
      ratio_q    <= ratio_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    from_req_d = from_req_q;
    err_d      = err_q;
    done_d     = 1'b0;
    tmr_load   = 1'b0;
    tmr_val    = '0;
    case (state_q)
      ST_INIT: begin
        state_d  = ST_SETTLE;
        tmr_load = 1'b1;
        tmr_val  = SETTLE_LOAD;
      end
      ST_RUN: begin
        if (accept) begin
          if (!req_legal) begin
            err_d = 1'b1;
          end else if (req_same) begin
            done_d = 1'b1;
            err_d  = 1'b0;
          end else begin
            pend_d     = I_req_ratio;
            err_d      = 1'b0;
            from_req_d = 1'b1;
            state_d    = ST_WAIT_LOW;
            tmr_load   = 1'b1;
            tmr_val    = TIMEOUT_LOAD;
          end
        end
      end
      ST_WAIT_LOW: begin
        if (!I_div_clk) begin
          state_d = ST_GATE;
        end else if (tmr_zero) begin
          state_d = ST_GATE;
          err_d   = 1'b1;
        end
      end
      ST_GATE: state_d = ST_APPLY;
      ST_APPLY: begin
        state_d  = ST_SETTLE;
        tmr_load = 1'b1;
        tmr_val  = SETTLE_LOAD;
      end
      ST_SETTLE: begin
        if (tmr_zero) begin
          state_d    = ST_RUN;
          done_d     = from_req_q;
          from_req_d = 1'b0;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  // Outputs are decoded from the next state so they register in step with it.
  always_comb begin
    en_d    = (state_d == ST_RUN) || (state_d == ST_WAIT_LOW);
    rst_n_d = !((state_d == ST_INIT) || (state_d == ST_APPLY));
    rdy_d   = (state_d == ST_RUN);
    busy_d  = (state_d != ST_RUN);
    ratio_d = (state_d == ST_APPLY) ? pend_q : ratio_q;
  end

  assign o_req_ready = rdy_q;
  assign o_div_en    = en_q;
  assign o_div_rst_n = rst_n_q;
  assign o_div_ratio = ratio_q;
  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_err       = err_q;

endmodule

// File: tb/tb_clk_div_ratio_ctrl.sv
// Directed bench: ratio sequencer driving a behavioural integer divider.
module tb_clk_div_ratio_ctrl;

  localparam int S = 4;
  localparam int T = 64;

  logic       clk;
  logic       rst;
  logic       req_valid;
  logic [7:0] req_ratio;
  logic       req_ready;
  logic       div_en;
  logic       div_rst_n;
  logic [7:0] div_ratio;
  logic       busy;
  logic       done;
  logic       err;

  logic       force_hi;
  logic [7:0] dcnt;
  logic       dclk;
  logic       div_clk_in;
  logic [7:0] dnxt;
  logic [7:0] dhalf;

  int n_chk = 0;
  int n_err = 0;

  clk_div_ratio_ctrl dut (
    .I_ref_clk   (clk),
    .I_rst       (rst),
    .I_req_valid (req_valid),
    .I_req_ratio (req_ratio),
    .o_req_ready (req_ready),
    .I_div_clk   (div_clk_in),
    .o_div_en    (div_en),
    .o_div_rst_n (div_rst_n),
    .o_div_ratio (div_ratio),
    .o_busy      (busy),
    .o_done      (done),
    .o_err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural divider: high for (ratio+1)/2 cycles of each ratio-cycle period.
  assign dnxt  = (dcnt + 8'd1 == div_ratio) ? 8'd0 : dcnt + 8'd1;
  assign dhalf = (div_ratio + 8'd1) >> 1;
  always_ff @(posedge clk) begin
    if (!div_rst_n) begin
      dcnt <= 8'd0;
      dclk <= 1'b0;
    end else if (div_en) begin
      dcnt <= dnxt;
      dclk <= (dnxt < dhalf);
    end
  end
  assign div_clk_in = force_hi ? 1'b1 : dclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_en"},    div_en,    0);
    chk({pfx, "_rst_n"}, div_rst_n, 0);
    chk({pfx, "_ratio"}, div_ratio, 2);
    chk({pfx, "_ready"}, req_ready, 0);
    chk({pfx, "_busy"},  busy,      1);
    chk({pfx, "_done"},  done,      0);
    chk({pfx, "_err"},   err,       0);
  endtask

  task automatic measure(input int n, output int hi, output int rises, output int min_hi);
    logic prev;
    int   run;
    logic seen_rise;
    hi = 0; rises = 0; min_hi = 999; run = 0; seen_rise = 1'b0;
    prev = div_clk_in;
    for (int i = 0; i < n; i++) begin
      cyc();
      if (div_clk_in) hi++;
      if (div_clk_in && !prev) begin
        rises++;
        seen_rise = 1'b1;
        run = 0;
      end
      if (div_clk_in) run++;
      if (!div_clk_in && prev && seen_rise && run < min_hi) min_hi = run;
      prev = div_clk_in;
    end
  endtask

  // Watches a reload sequence from just after acceptance until done or the bound.
  task automatic run_to_done(input int bound, output int lat, output int en_lo,
                             output int rstn_lo, output int bad);
    logic [7:0] prev_ratio;
    lat = 0; en_lo = 0; rstn_lo = 0; bad = 0;
    prev_ratio = div_ratio;
    while (done !== 1'b1 && lat < bound) begin
      cyc();
      lat++;
      if (!div_en) en_lo++;
      if (!div_rst_n) rstn_lo++;
      if (div_en && div_ratio !== prev_ratio) bad++;
      prev_ratio = div_ratio;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi, rises, min_hi, lat, en_lo, rstn_lo, bad, cnt;

    rst = 1'b1; req_valid = 1'b0; req_ratio = 8'd0; force_hi = 1'b0;
    cyc(3);
    chk_reset_vals("reset");

    // Release: INIT one cycle, SETTLE S cycles, then RUN.
    rst = 1'b0;
    cyc(S);
    chk("boot_en_low", div_en, 0);
    chk("boot_busy", busy, 1);
    cyc();
    chk("boot_en", div_en, 1);
    chk("boot_ready", req_ready, 1);
    chk("boot_busy_clr", busy, 0);
    chk("boot_no_done", done, 0);
    chk("boot_ratio", div_ratio, 2);
    chk("boot_rst_n", div_rst_n, 1);

    measure(20, hi, rises, min_hi);
    chk("div2_highs", hi, 10);
    chk("div2_rises", rises, 10);

    // Ratio 5 accepted while the divided clock will be low on the next edge.
    for (int i = 0; i < 4 && div_clk_in !== 1'b1; i++) cyc();
    chk("pre5_div_hi", div_clk_in, 1);
    req_valid = 1'b1; req_ratio = 8'd5;
    cyc();
    req_valid = 1'b0;
    chk("r5_ready_low", req_ready, 0);
    chk("r5_busy", busy, 1);
    chk("r5_en_waitlow", div_en, 1);
    run_to_done(100, lat, en_lo, rstn_lo, bad);
    chk("r5_latency", lat, 3 + S);
    chk("r5_en_low_cycles", en_lo, 2 + S);
    chk("r5_rst_pulses", rstn_lo, 1);
    chk("r5_ratio_while_en", bad, 0);
    chk("r5_ratio", div_ratio, 5);
    chk("r5_err", err, 0);
    chk("r5_ready", req_ready, 1);
    cyc();
    chk("r5_done_pulse", done, 0);
    measure(20, hi, rises, min_hi);
    chk("div5_highs", hi, 12);
    chk("div5_rises", rises, 4);
    chk("div5_min_high_ge2", (min_hi >= 2), 1);

    // Out-of-range low.
    req_valid = 1'b1; req_ratio = 8'd1;
    cyc();
    req_valid = 1'b0;
    chk("r1_err", err, 1);
    chk("r1_done", done, 0);
    chk("r1_ready", req_ready, 1);
    chk("r1_ratio", div_ratio, 5);
    cyc();
    chk("r1_no_done", done, 0);
    chk("r1_err_sticky", err, 1);

    // Same ratio: immediate done, err cleared, divider keeps running.
    req_valid = 1'b1; req_ratio = 8'd5;
    cyc();
    req_valid = 1'b0;
    chk("same_done", done, 1);
    chk("same_err_clr", err, 0);
    cnt = 0;
    if (!div_en) cnt++;
    for (int i = 0; i < 5; i++) begin
      cyc();
      if (!div_en) cnt++;
    end
    chk("same_en_never_low", cnt, 0);
    chk("same_done_pulse", done, 0);
    chk("same_ratio", div_ratio, 5);

    // Out-of-range high.
    req_valid = 1'b1; req_ratio = 8'd30;
    cyc();
    req_valid = 1'b0;
    chk("r30_err", err, 1);
    chk("r30_done", done, 0);
    chk("r30_ratio", div_ratio, 5);

    // Divided clock stuck high: timeout, still applies, err set.
    force_hi = 1'b1;
    req_valid = 1'b1; req_ratio = 8'd7;
    cyc();
    req_valid = 1'b0;
    chk("to_err_clr_on_accept", err, 0);
    run_to_done(200, lat, en_lo, rstn_lo, bad);
    chk("to_latency", lat, T + 2 + S);
    chk("to_err", err, 1);
    chk("to_ratio", div_ratio, 7);
    chk("to_rst_pulses", rstn_lo, 1);
    chk("to_ratio_while_en", bad, 0);
    cyc(30);
    force_hi = 1'b0;

    // Reset during SETTLE discards the new ratio.
    req_valid = 1'b1; req_ratio = 8'd9;
    cyc();
    req_valid = 1'b0;
    for (int i = 0; i < 100 && div_rst_n !== 1'b0; i++) cyc();
    chk("rs_apply_seen", div_rst_n, 0);
    cyc();
    chk("rs_settle_ratio", div_ratio, 9);
    chk("rs_settle_en", div_en, 0);
    rst = 1'b1;
    cyc();
    chk_reset_vals("midrst");
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < S + 1; i++) begin
      cyc();
      if (done) cnt++;
    end
    chk("rs_boot_en", div_en, 1);
    chk("rs_boot_ratio", div_ratio, 2);
    cyc(2);
    if (done) cnt++;
    chk("rs_no_done", cnt, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
